// File: rtl/stdout_uart.sv
// Formats each 16-bit core output word as four uppercase hex characters plus a line terminator
// and transmits them 8N1 on uart_tx_o. Define STDOUT_UART_CRLF_EN to send CR+LF instead of LF only.
module stdout_uart #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stdout_val_i,
  input  logic [15:0] stdout_data_i,
  output logic        stdout_rdy_o,
  output logic        uart_tx_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W    = $clog2(CLK_DIV);
  localparam int unsigned CHAR_W   = 3;
  localparam int unsigned BIT_W    = 3;
  localparam logic [7:0]  ASCII_CR = 8'h0D;
  localparam logic [7:0]  ASCII_LF = 8'h0A;
`ifdef STDOUT_UART_CRLF_EN
  localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(5);
`else
  localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(4);
`endif
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e              state_q;
  logic [15:0]         word_q;
  logic [CNT_W-1:0]    baud_q;
  logic [BIT_W-1:0]    bit_idx_q;
  logic [CHAR_W-1:0]   char_idx_q;
  logic                tx_q;
  logic                rdy_q;
  logic                busy_q;

  logic                baud_end_c;
  logic [7:0]          char_c;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + 8'(nib);
    end
    return 8'h37 + 8'(nib);
  endfunction

  assign baud_end_c = (baud_q == BAUD_LAST);

  // Character currently being serialised, selected by the character index.
  always_comb begin
    char_c = ASCII_LF;
    case (char_idx_q)
      3'd0: char_c = hex_char(word_q[15:12]);
      3'd1: char_c = hex_char(word_q[11:8]);
      3'd2: char_c = hex_char(word_q[7:4]);
      3'd3: char_c = hex_char(word_q[3:0]);
`ifdef STDOUT_UART_CRLF_EN
      3'd4: char_c = ASCII_CR;
      3'd5: char_c = ASCII_LF;
`else
      3'd4: char_c = ASCII_LF;
`endif
      default: char_c = ASCII_LF;
    endcase
  end

  // Frame sequencer; every output is a flop updated here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      word_q     <= 16'h0000;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      tx_q       <= 1'b1;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (stdout_val_i && rdy_q) begin
            word_q     <= stdout_data_i;
            state_q    <= START;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            char_idx_q <= '0;
            tx_q       <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        START: begin
          if (baud_end_c) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            tx_q      <= char_c[0];
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_end_c) begin
            baud_q <= '0;
            if (bit_idx_q == BIT_W'(7)) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + BIT_W'(1);
              tx_q      <= char_c[bit_idx_q + BIT_W'(1)];
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (baud_end_c) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            if (char_idx_q == LAST_CHAR) begin
              // Terminator done: one idle-high cycle follows before the next accept.
              state_q    <= IDLE;
              char_idx_q <= '0;
              tx_q       <= 1'b1;
              rdy_q      <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              char_idx_q <= char_idx_q + CHAR_W'(1);
              state_q    <= START;
              tx_q       <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx_o    = tx_q;
  assign stdout_rdy_o = rdy_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_stdout_uart.sv
// Directed bench for stdout_uart: decodes the serial line cycle by cycle against hand-computed bytes.
module tb_stdout_uart;

`ifdef STDOUT_UART_CRLF_EN
  localparam int NCHAR = 6;
`else
  localparam int NCHAR = 5;
`endif

  logic        clk = 1'b0;
  logic        rst, val, rst2, val2;
  logic [15:0] data, data2;
  logic        rdy, tx, busy, rdy2, tx2, busy2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stdout_uart #(.CLK_DIV(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .stdout_val_i(val), .stdout_data_i(data),
    .stdout_rdy_o(rdy), .uart_tx_o(tx), .busy_o(busy)
  );

  stdout_uart #(.CLK_DIV(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst2), .stdout_val_i(val2), .stdout_data_i(data2),
    .stdout_rdy_o(rdy2), .uart_tx_o(tx2), .busy_o(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of the first start-bit cycle; leaves at the negedge after the stop bit.
  task automatic recv_char(input int which, input logic [7:0] exp, input bit scramble,
                           output int lows);
    int         div;
    logic [7:0] b;
    logic       v, s, r;
    bit         ok;
    div  = (which == 0) ? 4 : 2;
    b    = 8'h00;
    v    = 1'b0;
    ok   = 1'b1;
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < div; c++) begin
        s = (which == 0) ? tx : tx2;
        r = (which == 0) ? rdy : rdy2;
        if (c == 0) v = s;
        else if (s !== v) ok = 1'b0;
        if (r === 1'b0) lows++;
        if (scramble) begin
          data = 16'($urandom);
          val  = 1'($urandom);
        end
        @(negedge clk);
      end
      if (k == 0 && v !== 1'b0) ok = 1'b0;
      if (k == 9 && v !== 1'b1) ok = 1'b0;
      if (k >= 1 && k <= 8) b[k-1] = v;
    end
    check($sformatf("char%0d_byte", which), 32'(b), 32'(exp));
    check($sformatf("char%0d_frame", which), 32'(ok), 32'd1);
  endtask

  task automatic recv_word(input int which, input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3, input bit scramble);
    logic [7:0] exp [NCHAR];
    int         lows, total, div;
    exp[0] = c0; exp[1] = c1; exp[2] = c2; exp[3] = c3;
`ifdef STDOUT_UART_CRLF_EN
    exp[4] = 8'h0D; exp[5] = 8'h0A;
`else
    exp[4] = 8'h0A;
`endif
    div   = (which == 0) ? 4 : 2;
    total = 0;
    for (int i = 0; i < NCHAR; i++) begin
      recv_char(which, exp[i], scramble, lows);
      total += lows;
    end
    check("rdy_low_cycles", 32'(total), 32'(NCHAR * 10 * div));
    check("idle_rdy", 32'((which == 0) ? rdy : rdy2), 32'd1);
    check("idle_tx", 32'((which == 0) ? tx : tx2), 32'd1);
  endtask

  initial begin
    int highs, lows;
    rst = 1'b1; val = 1'b0; data = 16'h0000;
    rst2 = 1'b1; val2 = 1'b0; data2 = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_rdy", 32'(rdy), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);

    // Word 0x1A2F.
    val = 1'b1; data = 16'h1A2F;
    @(negedge clk);
    val = 1'b0;
    check("start_tx", 32'(tx), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    recv_word(0, 8'h31, 8'h41, 8'h32, 8'h46, 1'b0);
    @(negedge clk);
    check("stay_idle_tx", 32'(tx), 32'd1);

    // 0x0000 then 0xFFFF with val held: one idle-high cycle between words.
    val = 1'b1; data = 16'h0000;
    @(negedge clk);
    recv_word(0, 8'h30, 8'h30, 8'h30, 8'h30, 1'b0);
    data = 16'hFFFF;
    @(negedge clk);
    val = 1'b0;
    check("b2b_start_tx", 32'(tx), 32'd0);
    check("b2b_rdy", 32'(rdy), 32'd0);
    recv_word(0, 8'h46, 8'h46, 8'h46, 8'h46, 1'b0);

    // 0xBEEF with inputs scrambled every cycle mid-frame.
    val = 1'b1; data = 16'hBEEF;
    @(negedge clk);
    recv_word(0, 8'h42, 8'h45, 8'h45, 8'h46, 1'b1);
    val = 1'b0;
    @(negedge clk);

    // Reset during data bit 3 of the second character of 0x1A2F.
    val = 1'b1; data = 16'h1A2F;
    @(negedge clk);
    val = 1'b0;
    recv_char(0, 8'h31, 1'b0, lows);
    repeat (17) @(negedge clk);
    check("pre_reset_bit3", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_rdy", 32'(rdy), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx === 1'b1 && rdy === 1'b1) highs++;
      @(negedge clk);
    end
    check("abort_line_high", 32'(highs), 32'd60);
    val = 1'b1; data = 16'h00C3;
    @(negedge clk);
    val = 1'b0;
    recv_word(0, 8'h30, 8'h30, 8'h43, 8'h33, 1'b0);

    // CLK_DIV=2: reset beats a simultaneous val.
    rst2 = 1'b1; val2 = 1'b1; data2 = 16'h1234;
    @(negedge clk);
    rst2 = 1'b0; val2 = 1'b0;
    check("rst_val_tx", 32'(tx2), 32'd1);
    check("rst_val_rdy", 32'(rdy2), 32'd1);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx2 === 1'b1 && busy2 === 1'b0) highs++;
      @(negedge clk);
    end
    check("rst_val_no_tx", 32'(highs), 32'd30);
    val2 = 1'b1;
    @(negedge clk);
    val2 = 1'b0;
    check("div2_start_tx", 32'(tx2), 32'd0);
    recv_word(1, 8'h31, 8'h32, 8'h33, 8'h34, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
